// File: rtl/usb_rx_deserializer.sv
// USB receive bit engine: SYNC detection, NRZI decoding, bit unstuffing,
// LSB-first deserialisation and EOP detection, one sampled line bit per strobe.
module usb_rx_deserializer #(
    parameter int unsigned SYNC_MIN_ZEROS = 5
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       bit_strobe,
    input  logic       line_j,
    input  logic       line_se0,
    output logic [7:0] data_out,
    output logic       byte_valid,
    output logic       rx_active,
    output logic       eop,
    output logic       align_err,
    output logic       stuff_err
);
    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_EOP} state_e;

    localparam logic [2:0] SyncMin = 3'(SYNC_MIN_ZEROS);

    state_e      state_q;
    logic        prev_level_q;
    logic [6:0]  shift_q;
    logic [2:0]  bit_cnt_q;
    logic [2:0]  ones_cnt_q;
    logic [2:0]  zero_cnt_q;
    logic        align_pend_q;
    logic [7:0]  data_q;
    logic        byte_valid_q;
    logic        rx_active_q;
    logic        eop_q;
    logic        align_err_q;
    logic        stuff_err_q;

    logic        dec_bit;
    logic [7:0]  byte_d;

    // Unchanged line level decodes as 1. The oldest of the seven held bits
    // sits in shift_q[0], so the completed byte is the new bit on top of them.
    assign dec_bit = (line_j == prev_level_q);
    assign byte_d  = {dec_bit, shift_q};

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q      <= S_IDLE;
            prev_level_q <= 1'b1;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            ones_cnt_q   <= '0;
            zero_cnt_q   <= '0;
            align_pend_q <= 1'b0;
            data_q       <= '0;
            byte_valid_q <= 1'b0;
            rx_active_q  <= 1'b0;
            eop_q        <= 1'b0;
            align_err_q  <= 1'b0;
            stuff_err_q  <= 1'b0;
        end else begin
            // NOTE: pulses default low each cycle; with non-blocking
            // assignments a later assignment below overrides this default.
            byte_valid_q <= 1'b0;
            eop_q        <= 1'b0;
            align_err_q  <= 1'b0;
            stuff_err_q  <= 1'b0;

            if (bit_strobe) begin
                case (state_q)
                    S_IDLE: begin
                        if (!line_se0 && !line_j) begin
                            state_q      <= S_SYNC;
                            zero_cnt_q   <= 3'd1;
                            prev_level_q <= 1'b0;
                        end else begin
                            prev_level_q <= 1'b1;
                        end
                    end

                    S_SYNC: begin
                        if (line_se0) begin
                            state_q      <= S_IDLE;
                            prev_level_q <= 1'b1;
                        end else if (!dec_bit) begin
                            prev_level_q <= line_j;
                            if (zero_cnt_q != 3'd7)
                                zero_cnt_q <= zero_cnt_q + 3'd1;
                        end else if (zero_cnt_q >= SyncMin) begin
                            state_q      <= S_DATA;
                            prev_level_q <= line_j;
                            rx_active_q  <= 1'b1;
                            bit_cnt_q    <= '0;
                            ones_cnt_q   <= '0;
                        end else begin
                            state_q      <= S_IDLE;
                            prev_level_q <= 1'b1;
                        end
                    end

                    S_DATA: begin
                        if (line_se0) begin
                            state_q      <= S_EOP;
                            align_pend_q <= (bit_cnt_q != 3'd0);
                        end else begin
                            prev_level_q <= line_j;
                            if (ones_cnt_q == 3'd6) begin
                                // Stuff slot: a 0 is dropped, a 1 is a violation.
                                if (!dec_bit) begin
                                    ones_cnt_q <= '0;
                                end else begin
                                    stuff_err_q  <= 1'b1;
                                    rx_active_q  <= 1'b0;
                                    state_q      <= S_IDLE;
                                    prev_level_q <= 1'b1;
                                end
                            end else begin
                                shift_q    <= byte_d[7:1];
                                bit_cnt_q  <= bit_cnt_q + 3'd1;
                                ones_cnt_q <= dec_bit ? ones_cnt_q + 3'd1 : 3'd0;
                                if (bit_cnt_q == 3'd7) begin
                                    data_q       <= byte_d;
                                    byte_valid_q <= 1'b1;
                                end
                            end
                        end
                    end

                    S_EOP: begin
                        if (!line_se0) begin
                            eop_q        <= 1'b1;
                            align_err_q  <= align_pend_q;
                            rx_active_q  <= 1'b0;
                            state_q      <= S_IDLE;
                            prev_level_q <= 1'b1;
                        end
                    end

                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign data_out   = data_q;
    assign byte_valid = byte_valid_q;
    assign rx_active  = rx_active_q;
    assign eop        = eop_q;
    assign align_err  = align_err_q;
    assign stuff_err  = stuff_err_q;

endmodule

// File: tb/tb_usb_rx_deserializer.sv
// Self-checking bench for usb_rx_deserializer: a line encoder (NRZI + bit
// stuffing) drives packets from a table, a negedge monitor scores the outputs.
module tb_usb_rx_deserializer;
    logic       clk = 1'b0;
    logic       nRST;
    logic       bit_strobe;
    logic       line_j;
    logic       line_se0;
    logic [7:0] data_out;
    logic       byte_valid;
    logic       rx_active;
    logic       eop;
    logic       align_err;
    logic       stuff_err;

    usb_rx_deserializer #(.SYNC_MIN_ZEROS(5)) dut (
        .clk        (clk),
        .nRST       (nRST),
        .bit_strobe (bit_strobe),
        .line_j     (line_j),
        .line_se0   (line_se0),
        .data_out   (data_out),
        .byte_valid (byte_valid),
        .rx_active  (rx_active),
        .eop        (eop),
        .align_err  (align_err),
        .stuff_err  (stuff_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] bits;      // payload, first transmitted bit in bit 0
        int          nbits;
        logic        exp_align;
        bit          gaps;      // sprinkle idle (non-strobe) cycles
        int          nz;        // decoded zeros in the SYNC pattern
    } pkt_t;

    typedef struct {
        logic [7:0] data;
        time        t;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    pkt_t tbl[9];

    int   n_checks  = 0;
    int   n_errors  = 0;
    int   eop_cnt   = 0;
    int   stuff_cnt = 0;
    int   rise_cnt  = 0;
    logic last_align = 1'b0;
    logic prev_rx    = 1'b0;

    // Encoder state: current line level and run of consecutive ones.
    logic lvl;
    int   ones;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (nRST) begin
            if (byte_valid) begin
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_byte", 32'(data_out), 32'(0));
                end else begin
                    mon_e = sb.pop_front();
                    check(data_out == mon_e.data, "byte_data", 32'(data_out), 32'(mon_e.data));
                    check($time == mon_e.t, "byte_latency", 32'($time), 32'(mon_e.t));
                end
            end
            if (eop) begin
                eop_cnt++;
                last_align = align_err;
                check(!rx_active, "rx_low_at_eop", 32'(rx_active), 32'(0));
            end
            if (align_err)
                check(eop, "align_with_eop", 32'(eop), 32'(1));
            if (stuff_err) begin
                stuff_cnt++;
                check(!rx_active && !byte_valid, "stuff_err_alone",
                      32'({rx_active, byte_valid}), 32'(0));
            end
            if (!prev_rx && rx_active)
                rise_cnt++;
            if (prev_rx && !rx_active)
                check(eop || stuff_err, "rx_fall_cause", 32'({eop, stuff_err}), 32'(1));
        end
        prev_rx = rx_active;
    end

    task automatic drive(input logic j, input logic se0);
        @(negedge clk);
        bit_strobe = 1'b1;
        line_j     = j;
        line_se0   = se0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bit_strobe = 1'b0;
        line_j     = 1'($urandom);
        line_se0   = 1'($urandom);
    endtask

    // K, then nz-1 alternations (nz decoded zeros), then a repeat (decoded 1).
    task automatic send_sync(input int nz);
        lvl = 1'b0;
        drive(lvl, 1'b0);
        for (int i = 1; i < nz; i++) begin
            lvl = ~lvl;
            drive(lvl, 1'b0);
        end
        drive(lvl, 1'b0);
        ones = 0;
    endtask

    // Stuff bit is inserted lazily, so six trailing ones leave it pending at SE0.
    task automatic send_data_bit(input logic b);
        if (ones == 6) begin
            lvl = ~lvl;
            drive(lvl, 1'b0);
            ones = 0;
        end
        if (!b) lvl = ~lvl;
        drive(lvl, 1'b0);
        ones = b ? ones + 1 : 0;
    endtask

    task automatic send_eop();
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
    endtask

    task automatic send_packet(input pkt_t p);
        int         eop0;
        int         stuff0;
        logic [7:0] last_byte;
        exp_t       e;
        eop0      = eop_cnt;
        stuff0    = stuff_cnt;
        last_byte = 8'h00;
        send_sync(p.nz);
        for (int i = 0; i < p.nbits; i++) begin
            send_data_bit(p.bits[i]);
            if (i == 0)
                check(rx_active == 1'b1, "rx_active_after_sync", 32'(rx_active), 32'(1));
            if (i % 8 == 7) begin
                last_byte = p.bits[i-7 +: 8];
                e.data = last_byte;
                e.t    = $time + 10;
                sb.push_back(e);
            end
            if (p.gaps && $urandom_range(0, 2) == 0)
                idle_cycle();
        end
        send_eop();
        for (int k = 0; k < 6 && eop_cnt == eop0; k++)
            idle_cycle();
        check(eop_cnt == eop0 + 1, "eop_count", 32'(eop_cnt - eop0), 32'(1));
        check(last_align == p.exp_align, "align_err", 32'(last_align), 32'(p.exp_align));
        check(sb.size() == 0, "bytes_missing", 32'(sb.size()), 32'(0));
        check(stuff_cnt == stuff0, "no_stuff_err", 32'(stuff_cnt - stuff0), 32'(0));
        if (p.nbits >= 8)
            check(data_out == last_byte, "data_out_hold", 32'(data_out), 32'(last_byte));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int eop0;
        int stuff0;
        int rise0;

        tbl[0] = '{24'h0000A5,  8, 1'b0, 1'b0, 7};
        tbl[1] = '{24'h0000FF, 16, 1'b0, 1'b0, 7};  // 0xFF (stuffed) then 0x00
        tbl[2] = '{24'h000A3C, 12, 1'b1, 1'b0, 7};  // 0x3C plus four spare bits
        tbl[3] = '{24'h0081FC, 16, 1'b0, 1'b0, 7};  // stuff bit at bit_cnt 0
        tbl[4] = '{24'h0000FC,  8, 1'b0, 1'b0, 7};  // stuff pending at SE0
        tbl[5] = '{24'h7EC35A, 24, 1'b0, 1'b1, 7};
        tbl[6] = '{24'hFFFFFF, 24, 1'b0, 1'b1, 7};
        tbl[7] = '{24'h000005,  3, 1'b1, 1'b0, 7};
        tbl[8] = '{24'h000069,  8, 1'b0, 1'b0, 5};  // minimum-length SYNC

        nRST       = 1'b0;
        bit_strobe = 1'b0;
        line_j     = 1'b1;
        line_se0   = 1'b0;
        lvl        = 1'b1;
        ones       = 0;

        repeat (6) begin
            @(negedge clk);
            bit_strobe = 1'($urandom);
            line_j     = 1'($urandom);
            line_se0   = 1'($urandom);
            check({data_out, byte_valid, rx_active, eop, align_err, stuff_err} == 13'h0,
                  "reset_outputs",
                  32'({data_out, byte_valid, rx_active, eop, align_err, stuff_err}), 32'(0));
        end
        @(negedge clk);
        bit_strobe = 1'b0;
        nRST       = 1'b1;
        repeat (8) drive(1'b1, 1'b0);
        idle_cycle();
        check({eop_cnt, stuff_cnt, rise_cnt} == '0, "idle_no_pulses",
              32'(eop_cnt + stuff_cnt + rise_cnt), 32'(0));
        check(data_out == 8'h00, "idle_data_out", 32'(data_out), 32'(0));

        for (int n = 0; n < 9; n++) begin
            send_packet(tbl[n]);
            repeat (2) idle_cycle();
        end

        // Seven decoded ones with no stuff bit.
        stuff0 = stuff_cnt;
        send_sync(7);
        for (int i = 0; i < 7; i++) begin
            drive(lvl, 1'b0);
            if (i == 0)
                check(rx_active == 1'b1, "rx_active_before_stuff", 32'(rx_active), 32'(1));
        end
        idle_cycle();
        check(stuff_err == 1'b1, "stuff_err_pulse", 32'(stuff_err), 32'(1));
        check(rx_active == 1'b0, "stuff_rx_low", 32'(rx_active), 32'(0));
        idle_cycle();
        check(stuff_err == 1'b0, "stuff_err_one_cycle", 32'(stuff_err), 32'(0));
        check(stuff_cnt == stuff0 + 1, "stuff_err_count", 32'(stuff_cnt - stuff0), 32'(1));
        repeat (3) drive(1'b1, 1'b0);
        send_packet(tbl[0]);

        // Short SYNCs: 3 and 4 decoded zeros are both below the minimum.
        eop0  = eop_cnt;
        rise0 = rise_cnt;
        repeat (3) drive(1'b1, 1'b0);
        send_sync(3);
        repeat (3) drive(1'b1, 1'b0);
        send_sync(4);
        repeat (3) drive(1'b1, 1'b0);
        idle_cycle();
        check(rise_cnt == rise0, "bad_sync_no_rx", 32'(rise_cnt - rise0), 32'(0));
        check(rx_active == 1'b0, "bad_sync_rx_low", 32'(rx_active), 32'(0));
        check(eop_cnt == eop0, "bad_sync_no_eop", 32'(eop_cnt - eop0), 32'(0));

        // Asynchronous reset in the middle of a byte.
        eop0 = eop_cnt;
        send_sync(7);
        for (int i = 0; i < 4; i++) send_data_bit(1'($urandom));
        #7;
        check(rx_active == 1'b1, "rx_active_mid_byte", 32'(rx_active), 32'(1));
        nRST = 1'b0;
        #1;
        check({data_out, byte_valid, rx_active, eop, align_err, stuff_err} == 13'h0,
              "async_reset_clear",
              32'({data_out, byte_valid, rx_active, eop, align_err, stuff_err}), 32'(0));
        @(negedge clk);
        bit_strobe = 1'b0;
        repeat (2) idle_cycle();
        nRST = 1'b1;
        rise0 = rise_cnt;
        repeat (4) drive(1'b1, 1'b0);
        idle_cycle();
        check(eop_cnt == eop0, "reset_no_eop", 32'(eop_cnt - eop0), 32'(0));
        check(rise_cnt == rise0, "reset_no_resume", 32'(rise_cnt - rise0), 32'(0));
        send_packet(tbl[1]);
        repeat (2) idle_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/usb_rx_deserializer.md
# usb_rx_deserializer

Receive-side bit engine of the USB transceiver, the counterpart of the transmit shift register. It takes one sampled line bit per strobe and performs SYNC detection, NRZI decoding, bit unstuffing, serial-to-parallel conversion (LSB first) and EOP detection. It sits between the line sampler / clock-recovery logic and the packet-level receive FSM, delivering one byte per `byte_valid` pulse.

## Interface
Parameters:
- `SYNC_MIN_ZEROS`, default 5: minimum decoded zeros before the SYNC-terminating one for SYNC to be accepted.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `bit_strobe` in 1: one line bit is sampled this cycle. May be high on consecutive cycles.
- `line_j` in 1: sampled differential level; 1 = J (idle), 0 = K. Valid only with `bit_strobe`.
- `line_se0` in 1: SE0 sampled. Valid only with `bit_strobe`; overrides `line_j`.
- `data_out` out 8: last completed byte; first received bit is in bit 0. Holds until the next byte completes.
- `byte_valid` out 1: one-cycle pulse; `data_out` is new.
- `rx_active` out 1: high from SYNC accepted until EOP or error.
- `eop` out 1: one-cycle pulse at end of packet.
- `align_err` out 1: one-cycle pulse, coincident with `eop`, when the packet did not end on a byte boundary.
- `stuff_err` out 1: one-cycle pulse on a bit-stuff violation.

## Operation
- Reset (async, `nRST`=0): state IDLE; `prev_level`=1 (J); shift register, `bit_cnt`, `ones_cnt`, `zero_cnt` = 0; all outputs 0, including `data_out`=0x00.
- NRZI decoding on a strobe (non-SE0): bit = 1 if `line_j == prev_level`, else 0. `prev_level <= line_j` on every non-SE0 strobe in SYNC and DATA, including stuffed bits. SE0 strobes never update `prev_level`.
- State machine (advances only on `bit_strobe`):
  - IDLE: `rx_active`=0. A K strobe (`line_j`=0, no SE0) moves to SYNC with `zero_cnt`=1 and `prev_level`=0. All other strobes are ignored, and `prev_level` is held at 1.
  - SYNC: a decoded 0 increments `zero_cnt` (saturating at 7). A decoded 1 with `zero_cnt >= SYNC_MIN_ZEROS` moves to DATA, sets `rx_active`, and clears `bit_cnt`/`ones_cnt`. A decoded 1 with fewer zeros, or an SE0, returns to IDLE with `prev_level`=1. No output pulses occur.
  - DATA, SE0 strobe: move to EOP. Latch `align_err_pending = (bit_cnt != 0)`. No further bits are shifted.
  - DATA, `ones_cnt == 6`: this bit is a stuff bit. A decoded 0 is discarded and `ones_cnt` is cleared. A decoded 1 pulses `stuff_err`, clears `rx_active`, returns to IDLE and sets `prev_level`=1. The partial byte is dropped.
  - DATA, otherwise: shift right with the new bit into bit 7, and increment `bit_cnt` (3-bit, wraps 7→0). A decoded 1 increments `ones_cnt`; a 0 clears it. When `bit_cnt` wraps, `data_out` takes the completed byte and `byte_valid` pulses.
  - EOP: SE0 strobes are ignored. The first non-SE0 strobe pulses `eop` (plus `align_err` if pending), clears `rx_active`, returns to IDLE and sets `prev_level`=1.
- Stuffing and byte count are independent: a stuff bit may occur at any `bit_cnt`, including 0.
- A stuff bit pending when SE0 arrives is not an error; normal EOP handling applies.

## Timing
- All outputs are registered. Each pulse appears the cycle after the rising edge that samples the causing strobe, and lasts exactly 1 cycle.
- `byte_valid` latency is 1 cycle after the strobe carrying the 8th non-stuffed data bit.
- `rx_active` rises 1 cycle after the SYNC-terminating strobe. It falls in the same cycle `eop` or `stuff_err` is high.
- `eop` and `align_err` are coincident. `stuff_err` never coincides with `byte_valid`.
- With back-to-back strobes, one byte can complete every 8 cycles, or every 9 cycles when a stuff bit is present. No backpressure is supported; the consumer must accept each `byte_valid`.
- Reset mid-packet: outputs clear immediately and asynchronously, with no `eop`. After reset release, reception resumes only after a new SYNC.

## Test plan
- Reset: hold `nRST`=0 while toggling strobes → all outputs 0, `data_out`=0x00; after release with idle J strobes → no pulses.
- SYNC (KJKJKJKK), byte 0xA5 NRZI-encoded, SE0 ×2, J → single `byte_valid` with `data_out`=0xA5, `rx_active` high between SYNC and `eop`, `eop` pulse, `align_err`=0.
- SYNC, 0xFF, stuff 0, 0x00, EOP → bytes 0xFF then 0x00, no `stuff_err`, stuff bit not shifted.
- SYNC, then 7 consecutive decoded ones → `stuff_err` pulse on the 7th, `rx_active` low the same cycle, no `byte_valid`, next SYNC received normally.
- SYNC, 12 data bits (first byte 0x3C), EOP → one `byte_valid` with 0x3C, then `eop` with `align_err`=1.
- Bad SYNC (K, J, K, then decoded 1 after 3 zeros) → returns to IDLE, `rx_active` never rises. Separately, `nRST` pulse mid-byte → immediate clear, no `eop`.
